ensamblador_punto_fijo: RTL and testbench
=========================================

Name: ensamblador_punto_fijo

Overview:
- Digit-serial decimal-to-fixed-point composer for the velocimetro datapath.
- Accepts a decimal number one BCD digit at a time: integer digits, an optional decimal comma, then one fractional digit.
- Emits the 24-bit fixed-point word in the speed format: bits [23:20] zero, [19:4] integer, [3:0] binary fraction in sixteenths.
- This is the inverse of the integer/fraction split: used for calibration and limit entry from the keypad into the fixed-point pipeline.

Parameters:
- MAX_DIGITOS, 5, maximum integer digits accepted before overflow is flagged.
- ANCHO_ENTERO, 16, integer field width. Fixed; changing it is not supported.
- ANCHO_FRAC, 4, fraction field width. Fixed; the rounding table is sized for 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inicio  in  1  one-cycle pulse; clears the accumulator and starts a new number.
- digito  in  4  BCD digit, 0..9.
- digito_valido  in  1  qualifies digito for one cycle.
- coma  in  1  one-cycle pulse; following digit is fractional.
- fin  in  1  one-cycle pulse; number complete.
- fixedPoint  out  24  assembled result {4'b0, entero[15:0], frac[3:0]}.
- valido  out  1  one-cycle pulse; fixedPoint updated.
- ocupado  out  1  high while a number is being entered.
- desborde  out  1  sticky; integer saturated. Cleared by inicio.
- error_digito  out  1  sticky; a digit >9 was received. Cleared by inicio.

Behaviour:
- Reset (async, rst_n=0): state REPOSO. fixedPoint=0, valido=0, ocupado=0, desborde=0, error_digito=0. Accumulator, fraction and digit count are 0.
- States: REPOSO, ENTERO, DECIMAL. ocupado = (state != REPOSO).
- Priority when pulses coincide: inicio > (digito_valido, then coma or fin).
- inicio in any state: acc=0, frac=0, cnt=0, flags cleared, state ENTERO. Any other input in that cycle is ignored.
- REPOSO: digito_valido, coma and fin are ignored.
- ENTERO + digito_valido with digito <= 9:
  - nxt = acc*10 + digito, computed as (acc<<3)+(acc<<1)+d in 20 bits.
  - If nxt > 65535 or cnt == MAX_DIGITOS: acc=65535, desborde=1.
  - Otherwise acc=nxt. cnt saturates at MAX_DIGITOS.
- Any state except REPOSO + digito_valido with digito > 9: digit discarded, error_digito=1, acc and frac unchanged.
- ENTERO + coma: state DECIMAL.
- DECIMAL + coma: ignored.
- DECIMAL + first valid digit: frac = round_half_up(d*16/10) using this table (d -> frac): 0->0, 1->2, 2->3, 3->5, 4->6, 5->8, 6->10, 7->11, 8->13, 9->14. Later fractional digits are ignored (truncated).
- fin in ENTERO or DECIMAL: on the next rising edge, fixedPoint={4'b0, acc', frac'} and valido=1 for exactly one cycle; state REPOSO.
  - acc' and frac' include a digit accepted in the same cycle as fin.
  - Latency is 1 cycle from fin sampled to valido.
- fixedPoint holds its value until the next valido, or reset. It is not cleared by inicio.
- fin with no digits entered yields fixedPoint=0 with a valido pulse.
- coma and fin together in ENTERO: treated as fin. The fraction stays 0.
- rst_n asserted mid-entry: immediate return to reset values. No valido is produced.

Decomposition:
- Shared package velocimetro_pkg holds:
  - state encoding (REPOSO/ENTERO/DECIMAL);
  - ANCHO_PUNTO_FIJO=24, ANCHO_ENTERO=16, ANCHO_FRAC=4, ENTERO_MAX=16'hFFFF;
  - the 10-entry decimal-tenth-to-sixteenths rounding constant table.
- One sub-module, mac_decimal: combinational acc*10+d with saturation and an overflow output. It is reusable for other keypad entry paths.

Test Plan:
- inicio; digits 1,2,3; coma; 4; fin -> one cycle later valido=1, fixedPoint=24'h0007B6, desborde=0.
- inicio; 6,5,5,3,5; coma; 9; fin -> fixedPoint=24'h0FFFFE. Then inicio; 7,0,0,0,0; fin -> fixedPoint=24'h0FFFF0, desborde=1.
- inicio; 4, then digito=4'hA, then 2; fin -> fixedPoint=24'h0002A0 (integer 42), error_digito=1. The next inicio clears error_digito.
- inicio; 8 with fin in the same cycle -> fixedPoint=24'h000080. inicio; fin (no digits) -> fixedPoint=0 with a valido pulse.
- inicio; 9; coma; 5; 7; fin -> fixedPoint=24'h000098 (second fractional digit ignored). Repeat with frac digits 0..9 to confirm the rounding table.
- inicio; 1,2; rst_n low for 1 cycle mid-entry -> all outputs 0, ocupado=0. A following fin produces no valido.

Source files
------------

// File: rtl/velocimetro_pkg.sv
// Shared definitions for the velocimetro fixed-point datapath.
//   estado_t          : keypad number entry states (REPOSO/ENTERO/DECIMAL)
//   ANCHO_*           : widths of the 24-bit speed word {4'b0, entero, frac}
//   ENTERO_MAX        : saturation value of the integer field
//   TABLA_DECIMOS     : decimal tenth -> sixteenths, rounded half up
package velocimetro_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ENTERO  = 2'd1,
        DECIMAL = 2'd2
    } estado_t;

    localparam int ANCHO_PUNTO_FIJO = 24;
    localparam int ANCHO_ENTERO     = 16;
    localparam int ANCHO_FRAC       = 4;

    localparam logic [15:0] ENTERO_MAX = 16'hFFFF;

    // Entry d holds round(d*16/10); index 0 is the rightmost nibble.
    localparam logic [9:0][3:0] TABLA_DECIMOS = {
        4'd14, 4'd13, 4'd11, 4'd10, 4'd8,
        4'd6,  4'd5,  4'd3,  4'd2,  4'd0
    };

    // Caller guarantees d <= 9.
    function automatic logic [3:0] decimo_a_dieciseisavos(input logic [3:0] d);
        return TABLA_DECIMOS[d];
    endfunction

endpackage

// File: rtl/mac_decimal.sv
// Combinational decimal shift-and-add: resultado = acc*10 + digito,
// saturated to ENTERO_MAX.
//   acc       : current integer accumulator
//   digito    : BCD digit to append (0..9)
//   resultado : saturated acc*10 + digito
//   desborde  : high when the unsaturated value exceeded ENTERO_MAX
module mac_decimal
    import velocimetro_pkg::*;
(
    input  logic [ANCHO_ENTERO-1:0] acc,
    input  logic [3:0]              digito,
    output logic [ANCHO_ENTERO-1:0] resultado,
    output logic                    desborde
);

    // 65535*10 + 9 fits in 20 bits, so the wide sum never wraps.
    logic [19:0] ampliado;

    always_comb begin
        ampliado  = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {16'b0, digito};
        desborde  = (ampliado > {4'b0, ENTERO_MAX});
        resultado = desborde ? ENTERO_MAX : ampliado[15:0];
    end

endmodule

// File: rtl/ensamblador_punto_fijo.sv
// Digit-serial decimal to fixed-point composer for keypad entry.
// Integer digits, an optional comma and one fractional digit are folded
// into the speed word {4'b0, entero[15:0], frac[3:0]}.
//   clk, rst_n     : clock, asynchronous active-low reset
//   inicio         : starts a new number (clears accumulator and flags)
//   digito         : BCD digit, qualified by digito_valido
//   coma           : following digit is fractional
//   fin            : number complete; result appears one cycle later
//   fixedPoint     : last assembled word, held until the next valido
//   valido         : one-cycle pulse when fixedPoint is updated
//   ocupado        : a number is being entered
//   desborde       : sticky integer saturation flag
//   error_digito   : sticky non-BCD digit flag
module ensamblador_punto_fijo
    import velocimetro_pkg::*;
#(
    parameter int MAX_DIGITOS  = 5,
    parameter int ANCHO_ENTERO = 16,
    parameter int ANCHO_FRAC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [3:0]  digito,
    input  logic        digito_valido,
    input  logic        coma,
    input  logic        fin,
    output logic [23:0] fixedPoint,
    output logic        valido,
    output logic        ocupado,
    output logic        desborde,
    output logic        error_digito
);

    localparam int CW = $clog2(MAX_DIGITOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITOS);
    localparam int RELLENO = ANCHO_PUNTO_FIJO - ANCHO_ENTERO - ANCHO_FRAC;

    estado_t                 estado_reg, estado_next;
    logic [ANCHO_ENTERO-1:0] acc_reg, acc_next;
    logic [ANCHO_FRAC-1:0]   frac_reg, frac_next;
    logic                    frac_tomada_reg, frac_tomada_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [23:0]             fixed_reg, fixed_next;
    logic                    valido_reg, valido_next;
    logic                    desborde_reg, desborde_next;
    logic                    error_reg, error_next;

    logic [ANCHO_ENTERO-1:0] mac_resultado;
    logic                    mac_desborde;
    logic                    digito_bueno;
    logic                    digito_malo;

    mac_decimal u_mac (
        .acc       (acc_reg),
        .digito    (digito),
        .resultado (mac_resultado),
        .desborde  (mac_desborde)
    );

    assign digito_bueno = digito_valido && (digito <= 4'd9);
    assign digito_malo  = digito_valido && (digito > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg      <= REPOSO;
            acc_reg         <= '0;
            frac_reg        <= '0;
            frac_tomada_reg <= 1'b0;
            cnt_reg         <= '0;
            fixed_reg       <= '0;
            valido_reg      <= 1'b0;
            desborde_reg    <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            estado_reg      <= estado_next;
            acc_reg         <= acc_next;
            frac_reg        <= frac_next;
            frac_tomada_reg <= frac_tomada_next;
            cnt_reg         <= cnt_next;
            fixed_reg       <= fixed_next;
            valido_reg      <= valido_next;
            desborde_reg    <= desborde_next;
            error_reg       <= error_next;
        end
    end

    always_comb begin
        estado_next      = estado_reg;
        acc_next         = acc_reg;
        frac_next        = frac_reg;
        frac_tomada_next = frac_tomada_reg;
        cnt_next         = cnt_reg;
        fixed_next       = fixed_reg;
        valido_next      = 1'b0;
        desborde_next    = desborde_reg;
        error_next       = error_reg;

        if (inicio) begin
            acc_next         = '0;
            frac_next        = '0;
            frac_tomada_next = 1'b0;
            cnt_next         = '0;
            desborde_next    = 1'b0;
            error_next       = 1'b0;
            estado_next      = ENTERO;
        end else if (estado_reg != REPOSO) begin
            if (digito_malo) begin
                error_next = 1'b1;
            end

            if (estado_reg == ENTERO && digito_bueno) begin
                // A sixth digit saturates even if the value itself would fit.
                if (mac_desborde || cnt_reg == CNT_MAX) begin
                    acc_next      = ENTERO_MAX;
                    desborde_next = 1'b1;
                end else begin
                    acc_next = mac_resultado;
                end
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // Only the first fractional digit counts; the rest truncate.
            if (estado_reg == DECIMAL && digito_bueno && !frac_tomada_reg) begin
                frac_next        = decimo_a_dieciseisavos(digito);
                frac_tomada_next = 1'b1;
            end

            // fin wins over a coincident coma; the word includes this
            // cycle's digit because it is built from the _next values.
            if (fin) begin
                fixed_next  = {{RELLENO{1'b0}}, acc_next, frac_next};
                valido_next = 1'b1;
                estado_next = REPOSO;
            end else if (coma && estado_reg == ENTERO) begin
                estado_next = DECIMAL;
            end
        end
    end

    assign fixedPoint   = fixed_reg;
    assign valido       = valido_reg;
    assign ocupado      = (estado_reg != REPOSO);
    assign desborde     = desborde_reg;
    assign error_digito = error_reg;

endmodule

// File: tb/tb_ensamblador_punto_fijo.sv
// Self-checking bench for ensamblador_punto_fijo. Expected words are pushed
// into a queue when fin is driven; a negedge monitor pops and compares them
// on every valido pulse.
module tb_ensamblador_punto_fijo;

    logic        clk;
    logic        rst_n;
    logic        inicio;
    logic [3:0]  digito;
    logic        digito_valido;
    logic        coma;
    logic        fin;
    logic [23:0] fixedPoint;
    logic        valido;
    logic        ocupado;
    logic        desborde;
    logic        error_digito;

    int errors = 0;
    int checks = 0;

    logic [23:0] cola[$];
    logic        valido_prev = 1'b0;

    // round(d*16/10), d = 0..9
    logic [3:0] tabla_esperada [10] = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd6,
                                        4'd8, 4'd10, 4'd11, 4'd13, 4'd14};

    ensamblador_punto_fijo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inicio        (inicio),
        .digito        (digito),
        .digito_valido (digito_valido),
        .coma          (coma),
        .fin           (fin),
        .fixedPoint    (fixedPoint),
        .valido        (valido),
        .ocupado       (ocupado),
        .desborde      (desborde),
        .error_digito  (error_digito)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (valido) begin
            checks++;
            if (valido_prev) begin
                errors++;
                $display("FAIL valido_width: valido high 2 cycles in a row, required 1-cycle pulse");
            end
            checks++;
            if (cola.size() == 0) begin
                errors++;
                $display("FAIL valido_unexpected: fixedPoint=%h with valido, required no valido", fixedPoint);
            end else begin
                logic [23:0] esperado;
                esperado = cola.pop_front();
                if (fixedPoint !== esperado) begin
                    errors++;
                    $display("FAIL fixedPoint: got %h, required %h", fixedPoint, esperado);
                end else begin
                    $display("txn fixedPoint=%h expected=%h ok", fixedPoint, esperado);
                end
            end
        end
        valido_prev <= valido;
    end

    // One input cycle; entered and left at posedge+1.
    task automatic paso(input logic ini, input logic dv, input logic [3:0] d,
                        input logic cm, input logic fn);
        inicio = ini; digito_valido = dv; digito = d; coma = cm; fin = fn;
        @(posedge clk); #1;
        inicio = 1'b0; digito_valido = 1'b0; digito = 4'd0; coma = 1'b0; fin = 1'b0;
    endtask

    task automatic dig(input logic [3:0] d);
        paso(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic empezar();
        paso(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic terminar(input logic [23:0] esperado);
        cola.push_back(esperado);
        paso(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic esperar_vacio(input string nombre);
        for (int i = 0; i < 8 && cola.size() != 0; i++) @(negedge clk);
        checks++;
        if (cola.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results pending, required 0", nombre, cola.size());
            cola.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fixedPoint, valido, ocupado, desborde, error_digito} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got fp=%h v=%b o=%b d=%b e=%b, required all 0",
                     fixedPoint, valido, ocupado, desborde, error_digito);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basico();
        empezar();
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL ocupado_entry: got %b, required 1", ocupado);
        end
        dig(4'd1); dig(4'd2); dig(4'd3);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dig(4'd4);
        checks++;
        if (valido !== 1'b0) begin
            errors++;
            $display("FAIL valido_early: got %b, required 0", valido);
        end
        terminar(24'h0007B6);
        checks++;
        if (valido !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL latency: got valido=%b ocupado=%b, required valido=1 ocupado=0", valido, ocupado);
        end
        esperar_vacio("basico");
        checks++;
        if (desborde !== 1'b0) begin
            errors++;
            $display("FAIL basico_desborde: got %b, required 0", desborde);
        end
    endtask

    task automatic test_desborde();
        empezar();
        dig(4'd6); dig(4'd5); dig(4'd5); dig(4'd3); dig(4'd5);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dig(4'd9);
        terminar(24'h0FFFFE);
        esperar_vacio("max");
        checks++;
        if (desborde !== 1'b0) begin
            errors++;
            $display("FAIL max_desborde: got %b, required 0", desborde);
        end
        empezar();
        dig(4'd7); dig(4'd0); dig(4'd0); dig(4'd0); dig(4'd0);
        terminar(24'h0FFFF0);
        esperar_vacio("70000");
        checks++;
        if (desborde !== 1'b1) begin
            errors++;
            $display("FAIL desborde_70000: got %b, required 1", desborde);
        end
        // Sixth digit saturates by count alone.
        empezar();
        checks++;
        if (desborde !== 1'b0) begin
            errors++;
            $display("FAIL desborde_clear: got %b, required 0", desborde);
        end
        for (int i = 0; i < 5; i++) dig(4'd0);
        dig(4'd1);
        terminar(24'h0FFFF0);
        esperar_vacio("seis");
        checks++;
        if (desborde !== 1'b1) begin
            errors++;
            $display("FAIL desborde_count: got %b, required 1", desborde);
        end
    endtask

    task automatic test_error_digito();
        empezar();
        dig(4'd4); dig(4'hA); dig(4'd2);
        terminar(24'h0002A0);
        esperar_vacio("error");
        checks++;
        if (error_digito !== 1'b1) begin
            errors++;
            $display("FAIL error_digito_set: got %b, required 1", error_digito);
        end
        empezar();
        checks++;
        if (error_digito !== 1'b0) begin
            errors++;
            $display("FAIL error_digito_clear: got %b, required 0", error_digito);
        end
        // Bad digit in the fraction keeps the fraction at 0, later good one lands.
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dig(4'hF); dig(4'd5);
        terminar(24'h000008);
        esperar_vacio("error_frac");
        checks++;
        if (error_digito !== 1'b1) begin
            errors++;
            $display("FAIL error_digito_frac: got %b, required 1", error_digito);
        end
    endtask

    task automatic test_fin_simultaneo();
        empezar();
        cola.push_back(24'h000080);
        paso(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        esperar_vacio("dig_fin");
        empezar();
        terminar(24'h000000);
        esperar_vacio("vacio");
        empezar();
        dig(4'd1);
        cola.push_back(24'h000010);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        esperar_vacio("coma_fin");
        // Fraction digit together with fin
        empezar();
        dig(4'd2);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cola.push_back(24'h00002D);
        paso(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        esperar_vacio("frac_fin");
    endtask

    task automatic test_redondeo();
        empezar();
        dig(4'd9);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dig(4'd5); dig(4'd7);
        terminar(24'h000098);
        esperar_vacio("trunc");
        for (int d = 0; d < 10; d++) begin
            logic [3:0] dd;
            dd = 4'(d);
            empezar();
            dig(4'd9);
            paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            dig(dd);
            dig(4'd9);
            terminar({4'b0, 16'd9, tabla_esperada[d]});
            esperar_vacio("tabla");
        end
    endtask

    task automatic test_back_to_back();
        empezar();
        dig(4'd3);
        terminar(24'h000030);
        empezar();
        dig(4'd5);
        paso(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        dig(4'd5);
        terminar(24'h000058);
        esperar_vacio("b2b");
        // Idle: digits and fin must be ignored (monitor flags any valido).
        dig(4'd7);
        paso(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (valido !== 1'b0 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL reposo_ignore: got valido=%b ocupado=%b, required 0 0", valido, ocupado);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_medio();
        empezar();
        dig(4'd1); dig(4'd2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fixedPoint, valido, ocupado, desborde, error_digito} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid: got fp=%h v=%b o=%b d=%b e=%b, required all 0",
                     fixedPoint, valido, ocupado, desborde, error_digito);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        paso(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (valido !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_fin: got valido=%b, required 0", valido);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        inicio = 1'b0; digito = 4'd0; digito_valido = 1'b0; coma = 1'b0; fin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basico();
        test_desborde();
        test_error_digito();
        test_fin_simultaneo();
        test_redondeo();
        test_back_to_back();
        test_reset_medio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
